// File: rtl/hamming_enc_stream_if.sv
// Byte-in / codeword-out handshake bundle for the streaming Hamming(7,4) encoder.
// master = upstream source + downstream sink side, slave = encoder side.
interface hamming_enc_stream_if;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] code_out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, code_out, out_valid
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, code_out, out_valid
  );
endinterface

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(7,4) encoder: byte in, two codewords (low nibble first) out via a small FIFO.
// Optional error injection on pushed codewords when HAMMING_ERR_INJ_EN is defined.
module hamming_enc_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef HAMMING_ERR_INJ_EN
  input  logic                     inj_en,
  input  logic [2:0]               inj_pos,
`endif
  hamming_enc_stream_if.slave      bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         cw_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ENC_LO, ENC_HI} state_t;

  state_t      state;
  logic [7:0]  byte_q;
  logic [6:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [6:0]  push_cw;

  function automatic logic [6:0] enc(input logic [3:0] n);
    return {n, n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0], n[2] ^ n[1] ^ n[0]};
  endfunction

  assign full  = (fifo_level == (AW+1)'(DEPTH));
  assign empty = (fifo_level == '0);
  assign push  = ((state == ENC_LO) || (state == ENC_HI)) && !full;
  assign pop   = bus.out_valid && bus.out_ready;

  // in_ready is gated by rst so it reads low for the whole reset window
  assign bus.in_ready  = !rst && ((state == IDLE) || ((state == ENC_HI) && !full));
  assign bus.out_valid = !empty;
  assign bus.code_out  = mem[rd_ptr];

  always_comb begin
    push_cw = enc((state == ENC_HI) ? byte_q[7:4] : byte_q[3:0]);
`ifdef HAMMING_ERR_INJ_EN
    if (inj_en && (inj_pos != 3'd7))
      push_cw[inj_pos] = ~push_cw[inj_pos];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      byte_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            byte_q <= bus.data_in;
            state  <= ENC_LO;
          end
        end
        ENC_LO: begin
          if (!full) state <= ENC_HI;
        end
        ENC_HI: begin
          if (!full) begin
            if (bus.in_valid) begin
              byte_q <= bus.data_in;
              state  <= ENC_LO;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cw_count   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_cw;
        wr_ptr      <= wr_ptr + AW'(1);
        cw_count    <= cw_count + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Directed self-checking bench for hamming_enc_stream (DEPTH=4, CNT_W=16).
module tb_hamming_enc_stream;
  logic        clk;
  logic        rst;
  logic [2:0]  fifo_level;
  logic [15:0] cw_count;
`ifdef HAMMING_ERR_INJ_EN
  logic        inj_en;
  logic [2:0]  inj_pos;
`endif

  int total = 0;
  int bad   = 0;
  logic [6:0] got [$];

  hamming_enc_stream_if bus ();

  hamming_enc_stream #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef HAMMING_ERR_INJ_EN
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
`endif
    .bus        (bus),
    .fifo_level (fifo_level),
    .cw_count   (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; record the codeword that the coming edge pops.
  task automatic step();
    if (bus.out_valid && bus.out_ready) got.push_back(bus.code_out);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.code_out !== 7'h00) begin bad++; $display("FAIL rst_code_out got=%h exp=00", bus.code_out); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    total++; if (cw_count !== 16'd0) begin bad++; $display("FAIL rst_cw_count got=%0d exp=0", cw_count); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single_byte();
    logic [6:0] exp_q [$];
    exp_q = '{7'h00, 7'h5A};
    got.delete();
    bus.out_ready = 1'b1;
    bus.data_in = 8'hB0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL sb_enc_lo_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sb_no_early_valid got=%b exp=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.code_out !== 7'h00) begin bad++; $display("FAIL sb_latency got=%b/%h exp=1/00", bus.out_valid, bus.code_out); end
    repeat (3) step();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL sb_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL sb_cw%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 7'hxx, exp_q[i]); end
    end
    total++; if (cw_count !== 16'd2) begin bad++; $display("FAIL sb_cw_count got=%0d exp=2", cw_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sb_ready_back got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_q [$];
    exp_q = '{7'h0F, 7'h7F, 7'h7F, 7'h00};
    got.delete();
    bus.out_ready = 1'b1;
    bus.data_in = 8'hF1; bus.in_valid = 1'b1;
    step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_c1 got=%b exp=0", bus.in_ready); end
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_c2 got=%b exp=1", bus.in_ready); end
    bus.data_in = 8'h0F;
    step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_c3 got=%b exp=0", bus.in_ready); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL b2b_level got=%0d exp=1", fifo_level); end
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_c4 got=%b exp=1", bus.in_ready); end
    repeat (4) step();
    total++; if (got.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_cw%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 7'hxx, exp_q[i]); end
    end
    total++; if (cw_count !== 16'd6) begin bad++; $display("FAIL b2b_cw_count got=%0d exp=6", cw_count); end
  endtask

  task automatic test_full_backpressure();
    got.delete();
    bus.out_ready = 1'b0;
    bus.data_in = 8'h21; bus.in_valid = 1'b1;
    step();
    step();
    bus.data_in = 8'h43;
    step();
    step();
    total++; if (fifo_level !== 3'd3 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_pre got=%0d/%b exp=3/1", fifo_level, bus.in_ready); end
    bus.data_in = 8'h65;
    step();
    bus.in_valid = 1'b0;
    step();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.code_out !== 7'h0F) begin bad++; $display("FAIL full_head got=%h exp=0F", bus.code_out); end
    total++; if (cw_count !== 16'd10) begin bad++; $display("FAIL full_cw_count got=%0d exp=10", cw_count); end
  endtask

  task automatic test_full_simul_pop();
    logic [6:0] exp_q [$];
    exp_q = '{7'h0F, 7'h13, 7'h1C, 7'h25, 7'h2A, 7'h36};
    bus.out_ready = 1'b1;
    step();
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL sp_level_pop got=%0d exp=3", fifo_level); end
    total++; if (cw_count !== 16'd10) begin bad++; $display("FAIL sp_no_push got=%0d exp=10", cw_count); end
    bus.out_ready = 1'b0;
    step();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL sp_level_push got=%0d exp=4", fifo_level); end
    bus.out_ready = 1'b1;
    repeat (8) step();
    total++; if (got.size() !== 6) begin bad++; $display("FAIL sp_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL sp_cw%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 7'hxx, exp_q[i]); end
    end
    total++; if (cw_count !== 16'd12 || fifo_level !== 3'd0) begin bad++; $display("FAIL sp_end got=%0d/%0d exp=12/0", cw_count, fifo_level); end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp_q [$];
    exp_q = '{7'h0F, 7'h00};
    got.delete();
    bus.out_ready = 1'b0;
    bus.data_in = 8'h37; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.out_valid); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL ar_level got=%0d exp=0", fifo_level); end
    total++; if (cw_count !== 16'd0) begin bad++; $display("FAIL ar_cw_count got=%0d exp=0", cw_count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.data_in = 8'h01; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL ar_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL ar_cw%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 7'hxx, exp_q[i]); end
    end
    total++; if (cw_count !== 16'd2) begin bad++; $display("FAIL ar_cw_count_after got=%0d exp=2", cw_count); end
  endtask

`ifdef HAMMING_ERR_INJ_EN
  function automatic logic [6:0] correct(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] r;
    s = {c[6]^c[5]^c[3]^c[2], c[6]^c[4]^c[3]^c[1], c[5]^c[4]^c[3]^c[0]};
    r = c;
    case (s)
      3'b110: r[6] = ~r[6];
      3'b101: r[5] = ~r[5];
      3'b011: r[4] = ~r[4];
      3'b111: r[3] = ~r[3];
      3'b100: r[2] = ~r[2];
      3'b010: r[1] = ~r[1];
      3'b001: r[0] = ~r[0];
      default: r = c;
    endcase
    return r;
  endfunction

  task automatic test_err_inj();
    logic [6:0] exp_q [$];
    exp_q = '{7'h52, 7'h00};
    got.delete();
    bus.out_ready = 1'b1;
    bus.data_in = 8'h0B; bus.in_valid = 1'b1;
    inj_en = 1'b1; inj_pos = 3'd3;
    step();
    bus.in_valid = 1'b0;
    step();
    inj_en = 1'b0; inj_pos = 3'd7;
    repeat (4) step();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL inj_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL inj_cw%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 7'hxx, exp_q[i]); end
    end
    if (got.size() > 0) begin
      total++; if (correct(got[0]) !== 7'h5A) begin bad++; $display("FAIL inj_corrected got=%h exp=5A", correct(got[0])); end
    end
    total++; if (cw_count !== 16'd4) begin bad++; $display("FAIL inj_cw_count got=%0d exp=4", cw_count); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.data_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
`ifdef HAMMING_ERR_INJ_EN
    inj_en = 1'b0;
    inj_pos = 3'd7;
`endif
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_backpressure();
    test_full_simul_pop();
    test_async_reset();
`ifdef HAMMING_ERR_INJ_EN
    test_err_inj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
